// File: rtl/jam_cost_port_arbiter_if.sv
// Engine-side bundle of the shared cost-table lookup port: per-engine request
// lanes, the registered W/J lookup address, the Cost read data and the routed responses.
interface jam_cost_port_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] req_w;
   logic [3*NREQ-1:0] req_j;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   gnt;
   logic [2:0]        W;
   logic [2:0]        J;
   logic [6:0]        Cost;
   logic [NREQ-1:0]   rsp_valid;
   logic [6:0]        rsp_cost;
   logic              busy;

   modport master (
      output req, req_w, req_j, req_last, Cost,
      input  gnt, W, J, rsp_valid, rsp_cost, busy
   );

   modport slave (
      input  req, req_w, req_j, req_last, Cost,
      output gnt, W, J, rsp_valid, rsp_cost, busy
   );
endinterface

// File: rtl/jam_cost_port_arbiter.sv
// Round-robin burst arbiter for the single cost-table port: grants whole lookup
// bursts to one engine at a time and routes each returning Cost back by tag.
module jam_cost_port_arbiter #(
   parameter int NREQ  = 2,
   parameter int LAT   = 1,
   parameter int BURST = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   jam_cost_port_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     owner, ptr, winner;
   logic              found;
   logic [CW-1:0]     beat_cnt;
   logic [NREQ-1:0]   gnt_c;
   logic              accept, last_beat;
   logic [2:0]        own_w, own_j;
   logic [2:0]        w_q, j_q;
   logic [LAT-1:0]    vld_p;
   logic [LAT-1:0][PW-1:0] tag_p;
   logic [NREQ-1:0]   rsp_valid_q;
   logic [6:0]        rsp_cost_q;

   function automatic logic [PW-1:0] wrap_idx(input int v);
      return PW'(v % NREQ);
   endfunction

   // Round-robin scan starting at ptr; NREQ need not be a power of two.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && bus.req[wrap_idx(int'(ptr) + k)]) begin
            found  = 1'b1;
            winner = wrap_idx(int'(ptr) + k);
         end
      end
   end

   always_comb begin
      own_w = '0;
      own_j = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == PW'(i)) begin
            own_w = bus.req_w[3*i +: 3];
            own_j = bus.req_j[3*i +: 3];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found)     state_nxt = S_BURST;
         S_BURST: if (last_beat) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Forced release fires on the beat that would bring beat_cnt to BURST.
   always_comb begin
      gnt_c     = '0;
      accept    = 1'b0;
      last_beat = 1'b0;
      if (state == S_BURST) begin
         gnt_c[owner] = bus.req[owner];
         accept       = bus.req[owner];
         last_beat    = bus.req[owner] &&
                        (bus.req_last[owner] || beat_cnt == CW'(BURST - 1));
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         owner    <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == S_IDLE && found) begin
            owner    <= winner;
            beat_cnt <= '0;
         end
         if (accept)    beat_cnt <= beat_cnt + CW'(1);
         if (last_beat) ptr      <= wrap_idx(int'(owner) + 1);
      end
   end

   // Stage p0: lookup address register and head of the tag pipeline.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         w_q   <= '0;
         j_q   <= '0;
         vld_p <= '0;
         tag_p <= '0;
      end else begin
         if (accept) begin
            w_q <= own_w;
            j_q <= own_j;
         end
         vld_p[0] <= accept;
         tag_p[0] <= owner;
         for (int k = 1; k < LAT; k++) begin
            vld_p[k] <= vld_p[k-1];
            tag_p[k] <= tag_p[k-1];
         end
      end
   end

   // Final stage: Cost is valid while the tag reaches the pipeline tail.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rsp_valid_q <= '0;
         rsp_cost_q  <= '0;
      end else begin
         rsp_valid_q <= '0;
         if (vld_p[LAT-1]) begin
            rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << tag_p[LAT-1];
            rsp_cost_q  <= bus.Cost;
         end
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.W         = w_q;
   assign bus.J         = j_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_cost  = rsp_cost_q;
   assign bus.busy      = (state != S_IDLE) || (|vld_p) || (|rsp_valid_q);
endmodule

// File: tb/tb_jam_cost_port_arbiter.sv
// Bench for jam_cost_port_arbiter: scripted and random engines, a latency-modelled
// cost table, and a burst-level reference model compared every cycle.
module tb_jam_cost_port_arbiter;
   localparam int NREQ  = 3;
   localparam int LAT   = 3;
   localparam int BURST = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   jam_cost_port_arbiter_if #(.NREQ(NREQ)) bus ();

   jam_cost_port_arbiter #(.NREQ(NREQ), .LAT(LAT), .BURST(BURST)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model state
   typedef struct {int due; int tag; int w; int j;} rsp_t;
   rsp_t pend[$];
   int   m_owner, m_ptr, m_beats, m_W, m_J;
   int   hist_w[LAT], hist_j[LAT];

   // engines
   int e_len[NREQ], e_idx[NREQ], e_hold[NREQ];
   int e_w[NREQ][16], e_j[NREQ][16];
   bit rand_mode = 1'b0;

   // observation logs
   int g_first[NREQ], g_last[NREQ], g_count[NREQ];
   int r_first_cyc[NREQ], r_last_cyc[NREQ], r_first_cost[NREQ], r_last_cost[NREQ], r_count[NREQ];
   int ord[$], segl[$];
   bit busy_at[int];

   function automatic int cost_of(input int w, input int j);
      return (w + 10 + 8 * j) % 128;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      for (int i = 0; i < NREQ; i++) begin
         g_first[i] = -1; g_last[i] = -1; g_count[i] = 0;
         r_first_cyc[i] = -1; r_last_cyc[i] = -1;
         r_first_cost[i] = -1; r_last_cost[i] = -1; r_count[i] = 0;
      end
      ord.delete();
      segl.delete();
   endtask

   task automatic start_burst(input int i, input int len, input bit pattern);
      e_len[i] = len;
      e_idx[i] = 0;
      for (int k = 0; k < 16; k++) begin
         e_w[i][k] = pattern ? (k % 8) : int'($urandom_range(0, 7));
         e_j[i][k] = pattern ? (7 - (k % 8)) : int'($urandom_range(0, 7));
      end
   endtask

   task automatic clear_model();
      m_owner = -1; m_ptr = 0; m_beats = 0; m_W = 0; m_J = 0;
      pend.delete();
      for (int k = 0; k < LAT; k++) begin hist_w[k] = 0; hist_j[k] = 0; end
   endtask

   // Registered outputs, sampled at the falling edge.
   task automatic check_regs();
      int exp_rv;
      int exp_cost;
      exp_rv   = 0;
      exp_cost = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_rv   = 1 << pend[0].tag;
         exp_cost = cost_of(pend[0].w, pend[0].j);
         void'(pend.pop_front());
      end
      chk("W", 32'(bus.W), m_W);
      chk("J", 32'(bus.J), m_J);
      chk("rsp_valid", 32'(bus.rsp_valid), exp_rv);
      if (exp_rv != 0) chk("rsp_cost", 32'(bus.rsp_cost), exp_cost);
      chk("busy", 32'(bus.busy), 32'((m_owner >= 0) || (exp_rv != 0) || (pend.size() > 0)));
      busy_at[cyc] = bus.busy;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.rsp_valid[i]) begin
            if (r_count[i] == 0) begin r_first_cyc[i] = cyc; r_first_cost[i] = int'(bus.rsp_cost); end
            r_last_cyc[i]  = cyc;
            r_last_cost[i] = int'(bus.rsp_cost);
            r_count[i]++;
         end
      end
   endtask

   task automatic drive_model();
      int exp_g;
      bit hit;
      for (int i = 0; i < NREQ; i++) begin
         bit stall;
         stall = 1'b0;
         if (e_hold[i] > 0) begin stall = 1'b1; e_hold[i]--; end
         if (rand_mode && e_len[i] == 0 && $urandom_range(0, 2) == 0)
            start_burst(i, int'($urandom_range(1, 12)), 1'b0);
         if (rand_mode && $urandom_range(0, 3) == 0) stall = 1'b1;
         bus.req[i]          = (e_len[i] > 0) && !stall;
         bus.req_w[3*i +: 3] = 3'(e_w[i][e_idx[i]]);
         bus.req_j[3*i +: 3] = 3'(e_j[i][e_idx[i]]);
         bus.req_last[i]     = (e_len[i] > 0) && (e_idx[i] == e_len[i] - 1);
      end
      // cost table: data appears LAT-1 cycles after the address is presented
      for (int k = LAT - 1; k > 0; k--) begin hist_w[k] = hist_w[k-1]; hist_j[k] = hist_j[k-1]; end
      hist_w[0] = int'(bus.W);
      hist_j[0] = int'(bus.J);
      bus.Cost  = 7'(cost_of(hist_w[LAT-1], hist_j[LAT-1]));
      #1;
      exp_g = 0;
      if (m_owner >= 0 && bus.req[m_owner]) exp_g = 1 << m_owner;
      chk("gnt", 32'(bus.gnt), exp_g);
      // model advances on the coming edge
      if (m_owner < 0) begin
         hit = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            int e;
            e = (m_ptr + k) % NREQ;
            if (!hit && bus.req[e]) begin hit = 1'b1; m_owner = e; m_beats = 0; end
         end
      end else if (bus.req[m_owner]) begin
         m_W = int'(bus.req_w[3*m_owner +: 3]);
         m_J = int'(bus.req_j[3*m_owner +: 3]);
         m_beats++;
         pend.push_back('{cyc + LAT + 1, m_owner, m_W, m_J});
         if (bus.req_last[m_owner] || m_beats == BURST) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (bus.gnt[i]) begin
            if (g_first[i] < 0) g_first[i] = cyc;
            g_last[i] = cyc;
            g_count[i]++;
            if (ord.size() == 0 || ord[ord.size()-1] != i) begin ord.push_back(i); segl.push_back(1); end
            else segl[segl.size()-1]++;
            if (e_len[i] > 0) begin
               e_idx[i]++;
               if (e_idx[i] == e_len[i]) begin e_len[i] = 0; e_idx[i] = 0; end
            end
         end
      end
   endtask

   task automatic step();
      @(negedge CLK);
      cyc++;
      check_regs();
      drive_model();
   endtask

   // Asynchronous reset mid-cycle; engines in post_mask start fresh bursts on release.
   task automatic reset_seq(input bit [NREQ-1:0] post_mask, input int post_len, input bit pattern);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("rst_W", 32'(bus.W), 0);
      chk("rst_J", 32'(bus.J), 0);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_cost", 32'(bus.rsp_cost), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      clear_model();
      clear_logs();
      for (int i = 0; i < NREQ; i++) begin
         e_len[i] = 0; e_idx[i] = 0; e_hold[i] = 0;
         if (post_mask[i]) start_burst(i, post_len, pattern);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      cyc++;
      check_regs();
      drive_model();
   endtask

   task automatic run_until_g(input int i, input int n, input string nm);
      int b;
      b = 0;
      while (g_count[i] < n && b < 200) begin step(); b++; end
      chk(nm, 32'(g_count[i] >= n), 1);
   endtask

   initial begin
      int low;
      bus.req = '0; bus.req_w = '0; bus.req_j = '0; bus.req_last = '0; bus.Cost = '0;
      for (int i = 0; i < NREQ; i++) begin e_len[i] = 0; e_idx[i] = 0; e_hold[i] = 0; end
      clear_model();
      clear_logs();

      // single requester, w=0..7, j=7-w
      reset_seq(3'b001, 8, 1'b1);
      repeat (20) step();
      chk("p1_first_gnt", g_first[0], 2);
      chk("p1_last_gnt", g_last[0], 9);
      chk("p1_beats", g_count[0], 8);
      chk("p1_first_rsp_cyc", r_first_cyc[0], 6);
      chk("p1_first_cost", r_first_cost[0], 66);
      chk("p1_last_cost", r_last_cost[0], 17);
      chk("p1_rsp_count", r_count[0], 8);

      // contention from reset: two bursts each for engines 0 and 1
      reset_seq(3'b011, 4, 1'b0);
      run_until_g(0, 4, "p2_wait0");
      run_until_g(1, 4, "p2_wait1");
      start_burst(0, 4, 1'b0);
      start_burst(1, 4, 1'b0);
      repeat (30) step();
      chk("p2_ord_size", ord.size(), 4);
      if (ord.size() >= 4) begin
         chk("p2_ord0", ord[0], 0);
         chk("p2_ord1", ord[1], 1);
         chk("p2_ord2", ord[2], 0);
         chk("p2_ord3", ord[3], 1);
      end

      // stall: engine1 owns, drops req for 3 cycles while engine0 waits
      clear_logs();
      start_burst(1, 6, 1'b0);
      run_until_g(1, 1, "p3_wait_first");
      start_burst(0, 2, 1'b0);
      run_until_g(1, 3, "p3_wait_third");
      e_hold[1] = 3;
      repeat (25) step();
      chk("p3_e1_span", g_last[1] - g_first[1], 8);
      chk("p3_e0_after_e1", 32'(g_first[0] > g_last[1]), 1);
      chk("p3_e0_beats", g_count[0], 2);

      // forced release after BURST beats
      clear_logs();
      start_burst(0, 12, 1'b0);
      run_until_g(0, 1, "p4_wait_first");
      start_burst(1, 4, 1'b0);
      repeat (40) step();
      chk("p4_segments", segl.size(), 3);
      if (segl.size() >= 3) begin
         chk("p4_seg0_len", segl[0], 8);
         chk("p4_seg1_eng", ord[1], 1);
         chk("p4_seg1_len", segl[1], 4);
         chk("p4_seg2_len", segl[2], 4);
      end

      // in-flight responses across an immediate handover
      clear_logs();
      start_burst(0, 3, 1'b0);
      step();
      start_burst(1, 3, 1'b0);
      repeat (25) step();
      chk("p5_e0_rsp", r_count[0], 3);
      chk("p5_rsp_order", 32'(r_last_cyc[0] < r_first_cyc[1] && r_first_cyc[1] > 0), 1);
      low = 0;
      for (int c = g_first[0]; c <= r_last_cyc[1]; c++)
         if (busy_at.exists(c) && !busy_at[c]) low++;
      chk("p5_busy_gaps", low, 0);

      // reset on beat 4 with responses in flight
      clear_logs();
      start_burst(0, 8, 1'b0);
      run_until_g(0, 4, "p6_wait_beat4");
      reset_seq(3'b111, 2, 1'b0);
      repeat (30) step();
      chk("p6_ord_size", ord.size(), 3);
      if (ord.size() >= 3) begin
         chk("p6_first_owner", ord[0], 0);
         chk("p6_second_owner", ord[1], 1);
      end
      chk("p6_e0_rsp", r_count[0], 2);

      // randomized traffic, then drain
      rand_mode = 1'b1;
      repeat (2000) step();
      rand_mode = 1'b0;
      repeat (80) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/jam_cost_port_arbiter.md
Name: jam_cost_port_arbiter

Overview:
- Shares the single external cost-table lookup port (W/J out, Cost in) between NREQ permutation-search engines.
- Each engine needs a burst of up to 8 lookups, one per worker, to cost a permutation. The arbiter grants whole bursts round-robin, drives W/J, and returns each Cost to the engine that issued the lookup.
- It sits between the search engines and the cost table in the job-assignment subsystem.

Parameters:
- NREQ, 2, number of requesting engines (2..4).
- LAT, 1, cycles from a registered W/J update to valid Cost on the input (1..3).
- BURST, 8, maximum accepted beats per grant before forced release.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-engine lookup request, level.
- req_w  in  3*NREQ  worker index per engine; engine i uses bits [3i+2:3i].
- req_j  in  3*NREQ  job index per engine; same slicing.
- req_last  in  NREQ  marks the final beat of the engine's burst.
- gnt  out  NREQ  combinational accept strobe; the beat is consumed this cycle.
- W  out  3  registered worker index to the cost table.
- J  out  3  registered job index to the cost table.
- Cost  in  7  cost-table read data.
- rsp_valid  out  NREQ  one-hot, registered; rsp_cost is valid for that engine.
- rsp_cost  out  7  registered copy of Cost.
- busy  out  1  high while the state is not IDLE or responses are in flight.

Behaviour:
- Reset values: W=0, J=0, gnt=0, rsp_valid=0, rsp_cost=0, busy=0. Internally: state=IDLE, owner=0, ptr=0, beat_cnt=0, tag pipeline cleared.
- Reset mid-burst: all in-flight responses are discarded and nothing is delivered after RST deasserts.
- State IDLE, arbitration:
  - Scan req starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - Register the winner as owner, clear beat_cnt, go to BURST.
  - No req set: stay in IDLE.
  - gnt is 0 throughout IDLE, so a request waits at least one cycle before its first grant.
- State BURST, beat acceptance:
  - gnt[owner] = req[owner]; all other gnt bits are 0.
  - On an accepted beat: W<=req_w[owner], J<=req_j[owner], beat_cnt+1, and push {valid=1, tag=owner} into a LAT-deep tag pipeline.
  - If req[owner] is low: no beat, W/J hold, the lock is kept, and the bubble pushes valid=0.
- End of burst:
  - A burst ends on the cycle that accepts a beat with req_last[owner]=1, or on the beat that brings beat_cnt to BURST (forced release), whichever comes first.
  - On exit: ptr <= (owner+1) mod NREQ, state -> IDLE. At least one IDLE cycle always separates bursts.
  - Forced release does not notify the engine. It keeps req high and is re-arbitrated fairly.
- Response path:
  - When the tag pipeline output is valid, on the next edge: rsp_valid <= one-hot(tag), rsp_cost <= Cost.
  - Total latency from gnt to rsp_valid is LAT+1 cycles.
  - Responses for beats accepted before a burst ends are still delivered to the issuing engine, even after ownership changes.
  - At most one rsp_valid bit is set per cycle. Responses stay in order.
- busy = (state != IDLE) or any tag-pipeline valid bit set or any rsp_valid bit set.
- Arithmetic and width:
  - beat_cnt is clog2(BURST)+1 bits.
  - ptr and owner are clog2(NREQ) bits with explicit mod-NREQ wrap; NREQ need not be a power of two.
- Simultaneous events:
  - A requester whose req_last beat is accepted may reassert req in the following cycle. It waits behind others per the round-robin pointer.
  - req from non-owners is ignored during BURST.

Test Plan:
- Single requester, NREQ=2, LAT=1: engine0 issues 8 beats (w=0..7, j=7-w), last on beat 8, Cost=w+10. Expect gnt[0] on 8 consecutive cycles after 1 IDLE cycle, W/J match each beat, and rsp_valid[0] 2 cycles after each gnt with rsp_cost=10..17.
- Contention: req=2'b11 from reset. Expect engine0 served first (ptr=0), then one IDLE cycle, then engine1's full burst, then engine0 again; ptr alternates 1,0,1.
- Stall: engine1 drops req for 3 cycles mid-burst with engine0 requesting. Expect no gnt during the stall, lock held, engine0 not granted until engine1's req_last beat, and W/J held during the stall.
- Forced release: engine0 never asserts req_last, BURST=8. Expect release after exactly 8 beats, then engine1 (requesting) granted next; engine0 regranted after engine1 finishes.
- In-flight across handover, LAT=3: engine0's last beat is followed immediately by engine1's burst. Expect engine0's final 3 responses on rsp_valid[0] before engine1's first rsp_valid[1], with busy continuously high.
- Reset mid-burst: assert RST on beat 4 with 3 responses in flight. Expect all outputs 0 immediately, no rsp_valid after release, and first grant after reset going to engine0.
